// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the memory pipeline stage and a 2^ADDR_W-byte data memory.
// Optional build macro DMEM_LSU_MISALIGN_TRAP_EN turns misaligned offsets into error responses.
module dmem_lsu #(
    parameter int              XLEN      = 64,
    parameter int              ADDR_W    = 12,
    parameter logic [XLEN-1:0] BASE_ADDR = 64'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_cs,
    output logic              mem_rw,
    output logic [1:0]        mem_word,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_dataw,
    input  logic [XLEN-1:0]   mem_datar
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // One extra bit so offset + size never wraps when compared against the memory span.
    localparam logic [XLEN:0] MEM_BYTES = {{XLEN{1'b0}}, 1'b1} << ADDR_W;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] offset;
    logic [XLEN:0]   nbytes;
    logic [XLEN:0]   access_end;
    logic            range_err;
    logic            req_err;
    logic            accept;
    logic            lat_unsigned;

    // ------------------------------------------------------------------
    // Request decode and error classification
    // ------------------------------------------------------------------
    assign offset     = req_addr - BASE_ADDR;
    assign nbytes     = {{XLEN{1'b0}}, 1'b1} << req_size;
    assign access_end = {1'b0, offset} + nbytes;
    assign range_err  = ({1'b0, offset} >= MEM_BYTES) || (access_end > MEM_BYTES);

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    logic align_err;
    assign align_err = |(offset & (nbytes[XLEN-1:0] - {{(XLEN-1){1'b0}}, 1'b1}));
    assign req_err   = range_err || align_err;
`else
    assign req_err   = range_err;
`endif

    assign req_ready = (state == IDLE) || ((state == RESP) && resp_ready);
    assign accept    = req_valid && req_ready;

    // ------------------------------------------------------------------
    // Load extension from the access width to XLEN
    // ------------------------------------------------------------------
    function automatic logic [XLEN-1:0] extend_load(
        input logic [XLEN-1:0] raw,
        input logic [1:0]      size,
        input logic            is_unsigned
    );
        logic [XLEN-1:0] res;
        res = raw;
        case (size)
            2'b00:   res = is_unsigned ? {{(XLEN-8){1'b0}}, raw[7:0]}
                                       : {{(XLEN-8){raw[7]}}, raw[7:0]};
            2'b01:   res = is_unsigned ? {{(XLEN-16){1'b0}}, raw[15:0]}
                                       : {{(XLEN-16){raw[15]}}, raw[15:0]};
            2'b10:   res = is_unsigned ? {{(XLEN-32){1'b0}}, raw[31:0]}
                                       : {{(XLEN-32){raw[31]}}, raw[31:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    if (accept) begin
                        state_next = req_err ? RESP : ACCESS;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory strobes and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            mem_cs       <= 1'b0;
            mem_rw       <= 1'b0;
            mem_word     <= 2'b00;
            mem_addr     <= '0;
            mem_dataw    <= '0;
            lat_unsigned <= 1'b0;
        end else begin
            // Strobes are single-cycle: they only survive an edge that enters ACCESS.
            mem_cs <= 1'b0;
            mem_rw <= 1'b0;

            if (accept) begin
                mem_word     <= req_size;
                mem_addr     <= offset[ADDR_W-1:0];
                mem_dataw    <= req_wdata;
                lat_unsigned <= req_unsigned;
                resp_rdata   <= '0;
                if (req_err) begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                end else begin
                    mem_cs     <= 1'b1;
                    mem_rw     <= req_we;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                end
            end else if (state == ACCESS) begin
                // mem_rw still holds the request direction during ACCESS.
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                resp_rdata <= mem_rw ? '0 : extend_load(mem_datar, mem_word, lat_unsigned);
            end else if ((state == RESP) && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: table-driven directed bench for dmem_lsu with a byte-array memory model.
// Build with or without DMEM_LSU_MISALIGN_TRAP_EN; the misalign vectors adapt to the macro.
module tb_dmem_lsu;

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_cs;
    logic        mem_rw;
    logic [1:0]  mem_word;
    logic [11:0] mem_addr;
    logic [63:0] mem_dataw;
    logic [63:0] mem_datar;

    logic [7:0]  mem [0:4095];
    int          errors = 0;
    int          checks = 0;
    int          cs_cycles = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    dmem_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_cs       (mem_cs),
        .mem_rw       (mem_rw),
        .mem_word     (mem_word),
        .mem_addr     (mem_addr),
        .mem_dataw    (mem_dataw),
        .mem_datar    (mem_datar)
    );

    always #5 clk = ~clk;

    // Read data outside chip-select is a poison pattern standing in for high-Z.
    always_comb begin
        mem_datar = 64'hDEAD_BEEF_DEAD_BEEF;
        if (mem_cs) begin
            for (int b = 0; b < 8; b++) begin
                mem_datar[8*b +: 8] = mem[mem_addr + 12'(b)];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_cs) begin
            cs_cycles++;
            if (mem_rw) begin
                for (int b = 0; b < (1 << mem_word); b++) begin
                    mem[mem_addr + 12'(b)] <= mem_dataw[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [63:0] addr, input logic [63:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int cs0;
        cs0 = cs_cycles;
        @(negedge clk);
        drive_req(v.we, v.size, v.uns, v.addr, v.wdata);
        lat = 0;
        while (!req_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d_ready", idx), 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
        check($sformatf("v%0d_rdata", idx), resp_rdata, v.exp_rdata);
        check($sformatf("v%0d_err", idx), 64'(resp_err), 64'(v.exp_err));
        check($sformatf("v%0d_cs_cycles", idx), 64'(cs_cycles - cs0), v.exp_err ? 64'd0 : 64'd1);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check($sformatf("v%0d_idle_valid", idx), 64'(resp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        // {we, size, uns, addr, wdata, exp_rdata, exp_err, exp_lat}
        vecs.push_back('{1'b1, 2'd3, 1'b0, 64'h10,  64'h1122334455667788, 64'h0, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 64'h10,  64'h0, 64'h1122334455667788, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd3, 1'b1, 64'h10,  64'h0, 64'h1122334455667788, 1'b0, 2});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 64'h20,  64'hFFFF_FF80, 64'h0, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 64'h20,  64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 64'h20,  64'h0, 64'h0000000000000080, 1'b0, 2});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 64'h22,  64'h8001, 64'h0, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 64'h22,  64'h0, 64'hFFFFFFFFFFFF8001, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 64'h22,  64'h0, 64'h0000000000008001, 1'b0, 2});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 64'h24,  64'h89ABCDEF, 64'h0, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 64'h24,  64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd2, 1'b1, 64'h24,  64'h0, 64'h0000000089ABCDEF, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 64'hFFE, 64'h0, 64'h0, 1'b1, 1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 64'h1000, 64'h0, 64'h0, 1'b1, 1});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 64'hFFC, 64'hCAFEF00D, 64'h0, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd2, 1'b1, 64'hFFC, 64'h0, 64'h00000000CAFEF00D, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 64'hFF8, 64'h0, 64'hCAFEF00D00000000, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 64'hFFC, 64'h0, 64'h0, 1'b1, 1});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 64'hFFF, 64'h0, 64'hFFFFFFFFFFFFFFCA, 1'b0, 2});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h55, 64'h0, 1'b1, 1});
        // Misaligned store then an aligned readback of the surrounding bytes.
        vecs.push_back('{1'b1, 2'd1, 1'b0, 64'h31, 64'hBEEF, 64'h0, TRAP, TRAP ? 1 : 2});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 64'h30, 64'h0,
                         TRAP ? 64'h0 : 64'h0000000000BEEF00, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 64'h31, 64'h0,
                         TRAP ? 64'h0 : 64'h000000000000BEEF, TRAP, TRAP ? 1 : 2});

        // Reset state
        #12;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_mem_cs", 64'(mem_cs), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-pressure followed by a back-to-back accept.
        @(negedge clk);
        drive_req(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
        @(posedge clk);
        #1;
        drive_req(1'b0, 2'd0, 1'b0, 64'h20, 64'h0);
        check("bp_access_cs", 64'(mem_cs), 64'd1);
        @(posedge clk);
        #1;
        check("bp_first_valid", 64'(resp_valid), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", c), 64'(resp_valid), 64'd1);
            check($sformatf("bp_hold%0d_rdata", c), resp_rdata, 64'h1122334455667788);
            check($sformatf("bp_hold%0d_ready", c), 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        #1;
        check("b2b_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        check("b2b_access_cs", 64'(mem_cs), 64'd1);
        check("b2b_access_addr", 64'(mem_addr), 64'h20);
        check("b2b_valid_low", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1;
        check("b2b_valid", 64'(resp_valid), 64'd1);
        check("b2b_rdata", resp_rdata, 64'hFFFFFFFFFFFFFF80);
        check("b2b_err", 64'(resp_err), 64'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;

        // Reset asserted in the middle of a load's ACCESS cycle.
        @(negedge clk);
        drive_req(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rstacc_cs_before", 64'(mem_cs), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstacc_cs", 64'(mem_cs), 64'd0);
        check("rstacc_valid", 64'(resp_valid), 64'd0);
        check("rstacc_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstacc_no_resp", 64'(resp_valid), 64'd0);
        check("rstacc_idle_ready", 64'(req_ready), 64'd1);
        run_vec('{1'b0, 2'd0, 1'b1, 64'h20, 64'h0, 64'h80, 1'b0, 2}, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
